// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the RV32 pipeline controller: FSM state, stage valid
// bundle, per-cycle pipeline action and the forwarding/priority encodings
// also used by the hazard unit.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } state_t;

  typedef struct packed {
    logic id;
    logic ex;
    logic mem;
    logic wb;
  } pipe_valid_t;

  // What the pipeline does this cycle, highest priority first.
  typedef enum logic [1:0] {
    ACT_HOLD   = 2'd0,
    ACT_FLUSH  = 2'd1,
    ACT_STALL  = 2'd2,
    ACT_NORMAL = 2'd3
  } pipe_act_t;

  // Operand forwarding selects, shared with the hazard unit.
  localparam logic [1:0] FWD_NONE   = 2'b00;
  localparam logic [1:0] FWD_MEM_WB = 2'b01;
  localparam logic [1:0] FWD_EX_MEM = 2'b10;

  // Priority ranks (lower wins), shared with the hazard unit.
  localparam logic [1:0] PRIO_MEM_WAIT = 2'd0;
  localparam logic [1:0] PRIO_FLUSH    = 2'd1;
  localparam logic [1:0] PRIO_STALL    = 2'd2;
  localparam logic [1:0] PRIO_NORMAL   = 2'd3;

  // Resolve the qualified events into one action: memory wait freezes
  // everything, a taken branch beats a load-use stall.
  function automatic pipe_act_t pick_action(input logic mem_wait,
                                            input logic flush_eff,
                                            input logic stall_eff);
    pipe_act_t act;
    if (mem_wait) begin
      act = ACT_HOLD;
    end else if (flush_eff) begin
      act = ACT_FLUSH;
    end else if (stall_eff) begin
      act = ACT_STALL;
    end else begin
      act = ACT_NORMAL;
    end
    return act;
  endfunction

  // True while any stage still carries an instruction.
  function automatic logic pipe_busy(input pipe_valid_t v);
    return v.id | v.ex | v.mem | v.wb;
  endfunction

endpackage

// File: rtl/pipe_perf_cnt.sv
// Stall / flush / retire performance counters for the pipeline controller.
// Only compiled when PIPE_PERF_CNT_EN is defined; counters wrap naturally.
`ifdef PIPE_PERF_CNT_EN
module pipe_perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_inc,
  input  logic             flush_inc,
  input  logic             retire_inc,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count,
  output logic [CNT_W-1:0] retire_count
);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  logic [CNT_W-1:0] stall_cnt_r;
  logic [CNT_W-1:0] flush_cnt_r;
  logic [CNT_W-1:0] retire_cnt_r;

  // Advance each counter on its increment strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_r  <= CNT_ZERO;
      flush_cnt_r  <= CNT_ZERO;
      retire_cnt_r <= CNT_ZERO;
    end else begin
      if (stall_inc)  stall_cnt_r  <= stall_cnt_r + CNT_ONE;
      if (flush_inc)  flush_cnt_r  <= flush_cnt_r + CNT_ONE;
      if (retire_inc) retire_cnt_r <= retire_cnt_r + CNT_ONE;
    end
  end

  assign stall_cycles = stall_cnt_r;
  assign flush_count  = flush_cnt_r;
  assign retire_count = retire_cnt_r;

endmodule
`endif

// File: rtl/pipeline_ctrl.sv
// 5-stage RV32 pipeline controller: turns hazard/branch/memory handshakes
// into per-stage register enables, stage valid bits, the ID/EX bubble and
// PC hold, and sequences boot and the debug halt/drain.
// Optional: define PIPE_PERF_CNT_EN to build the performance counters;
// otherwise the counter outputs are constant zero.
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int BOOT_DELAY = 2,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_req,
  input  logic             flush_req,
  input  logic             mem_wait,
  input  logic             imem_valid,
  input  logic             halt_req,
  output logic             pc_enable,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             id_ex_bubble,
  output logic             valid_id,
  output logic             valid_ex,
  output logic             valid_mem,
  output logic             valid_wb,
  output logic             retire,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count,
  output logic [CNT_W-1:0] retire_count
);

  localparam int BOOT_W = (BOOT_DELAY < 1) ? 1 : $clog2(BOOT_DELAY + 1);
  localparam logic [BOOT_W-1:0] BOOT_LAST = BOOT_W'(BOOT_DELAY);

  state_t            state_r;
  logic [BOOT_W-1:0] boot_cnt_r;
  pipe_valid_t       valid_r;
  logic              halted_r;

  logic        active_s;
  logic        stall_eff_s;
  logic        flush_eff_s;
  logic        fetch_ok_s;
  pipe_act_t   act_s;
  pipe_valid_t valid_nxt_s;
  logic        pc_en_s;
  logic        if_id_en_s;
  logic        id_ex_en_s;
  logic        ex_mem_en_s;
  logic        mem_wb_en_s;
  logic        bubble_s;

  assign active_s    = (state_r == RUN) || (state_r == DRAIN);
  assign stall_eff_s = stall_req & valid_r.id & valid_r.ex;
  assign flush_eff_s = flush_req & valid_r.ex;
  assign fetch_ok_s  = imem_valid & (state_r == RUN);

  // Pick this cycle's action and derive enables and next stage valids.
  always_comb begin
    pc_en_s     = 1'b0;
    if_id_en_s  = 1'b0;
    id_ex_en_s  = 1'b0;
    ex_mem_en_s = 1'b0;
    mem_wb_en_s = 1'b0;
    bubble_s    = 1'b0;
    valid_nxt_s = valid_r;
    act_s       = pick_action(mem_wait, flush_eff_s, stall_eff_s);
    if (active_s) begin
      case (act_s)
        ACT_HOLD: begin
          valid_nxt_s = valid_r;
        end
        ACT_FLUSH: begin
          // Target PC is captured even while draining so resume is correct.
          pc_en_s         = 1'b1;
          if_id_en_s      = 1'b1;
          id_ex_en_s      = 1'b1;
          ex_mem_en_s     = 1'b1;
          mem_wb_en_s     = 1'b1;
          valid_nxt_s.id  = 1'b0;
          valid_nxt_s.ex  = 1'b0;
          valid_nxt_s.mem = valid_r.ex;
          valid_nxt_s.wb  = valid_r.mem;
        end
        ACT_STALL: begin
          id_ex_en_s      = 1'b1;
          ex_mem_en_s     = 1'b1;
          mem_wb_en_s     = 1'b1;
          bubble_s        = 1'b1;
          valid_nxt_s.id  = valid_r.id;
          valid_nxt_s.ex  = 1'b0;
          valid_nxt_s.mem = valid_r.ex;
          valid_nxt_s.wb  = valid_r.mem;
        end
        ACT_NORMAL: begin
          pc_en_s         = fetch_ok_s;
          if_id_en_s      = 1'b1;
          id_ex_en_s      = 1'b1;
          ex_mem_en_s     = 1'b1;
          mem_wb_en_s     = 1'b1;
          valid_nxt_s.id  = fetch_ok_s;
          valid_nxt_s.ex  = valid_r.id;
          valid_nxt_s.mem = valid_r.ex;
          valid_nxt_s.wb  = valid_r.mem;
        end
        default: begin
          valid_nxt_s = valid_r;
        end
      endcase
    end else begin
      valid_nxt_s = valid_r;
    end
  end

  // Boot / run / drain / halted sequencing with registered valids and halted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= BOOT;
      boot_cnt_r  <= {BOOT_W{1'b0}};
      valid_r.id  <= 1'b0;
      valid_r.ex  <= 1'b0;
      valid_r.mem <= 1'b0;
      valid_r.wb  <= 1'b0;
      halted_r    <= 1'b0;
    end else begin
      valid_r <= valid_nxt_s;
      case (state_r)
        BOOT: begin
          if (boot_cnt_r == BOOT_LAST) begin
            state_r <= halt_req ? DRAIN : RUN;
          end else begin
            boot_cnt_r <= boot_cnt_r + BOOT_W'(1'b1);
          end
        end
        RUN: begin
          if (halt_req) state_r <= DRAIN;
        end
        DRAIN: begin
          // Halt request is latched here: only an empty, idle pipe exits.
          if (!pipe_busy(valid_r) && !mem_wait) begin
            state_r  <= HALTED;
            halted_r <= 1'b1;
          end
        end
        HALTED: begin
          if (!halt_req) begin
            state_r  <= RUN;
            halted_r <= 1'b0;
          end
        end
        default: begin
          state_r <= BOOT;
        end
      endcase
    end
  end

  assign pc_enable    = pc_en_s;
  assign if_id_en     = if_id_en_s;
  assign id_ex_en     = id_ex_en_s;
  assign ex_mem_en    = ex_mem_en_s;
  assign mem_wb_en    = mem_wb_en_s;
  assign id_ex_bubble = bubble_s;
  assign valid_id     = valid_r.id;
  assign valid_ex     = valid_r.ex;
  assign valid_mem    = valid_r.mem;
  assign valid_wb     = valid_r.wb;
  assign retire       = valid_r.wb & ~mem_wait;
  assign halted       = halted_r;

`ifdef PIPE_PERF_CNT_EN
  logic stall_inc_s;
  logic flush_inc_s;

  assign stall_inc_s = active_s & (act_s == ACT_STALL);
  assign flush_inc_s = active_s & (act_s == ACT_FLUSH);

  pipe_perf_cnt #(
    .CNT_W (CNT_W)
  ) u_perf_cnt (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall_inc    (stall_inc_s),
    .flush_inc    (flush_inc_s),
    .retire_inc   (retire),
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count),
    .retire_count (retire_count)
  );
`else
  assign stall_cycles = {CNT_W{1'b0}};
  assign flush_count  = {CNT_W{1'b0}};
  assign retire_count = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: an instruction-tag model of the
// pipeline is compared against the DUT every cycle, plus literal checks of
// boot latency, stall/flush counts, drain retires and async reset.
module tb_pipeline_ctrl;

  localparam int BD = 2;
  localparam int CW = 32;
`ifdef PIPE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n, stall_req, flush_req, mem_wait, imem_valid, halt_req;
  logic pc_enable, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, id_ex_bubble;
  logic valid_id, valid_ex, valid_mem, valid_wb, retire, halted;
  logic [CW-1:0] stall_cycles, flush_count, retire_count;

  logic z_pc, z_ifid, z_idex, z_exmem, z_memwb, z_bub;
  logic z_vid, z_vex, z_vmem, z_vwb, z_ret, z_halted;
  logic [CW-1:0] z_sc, z_fc, z_rc;

  always #5 clk = ~clk;

  pipeline_ctrl #(.BOOT_DELAY(BD), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .stall_req(stall_req), .flush_req(flush_req),
    .mem_wait(mem_wait), .imem_valid(imem_valid), .halt_req(halt_req),
    .pc_enable(pc_enable), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
    .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en), .id_ex_bubble(id_ex_bubble),
    .valid_id(valid_id), .valid_ex(valid_ex), .valid_mem(valid_mem),
    .valid_wb(valid_wb), .retire(retire), .halted(halted),
    .stall_cycles(stall_cycles), .flush_count(flush_count),
    .retire_count(retire_count));

  // Second instance covering the zero boot delay corner.
  pipeline_ctrl #(.BOOT_DELAY(0), .CNT_W(CW)) dut0 (
    .clk(clk), .rst_n(rst_n), .stall_req(stall_req), .flush_req(flush_req),
    .mem_wait(mem_wait), .imem_valid(imem_valid), .halt_req(halt_req),
    .pc_enable(z_pc), .if_id_en(z_ifid), .id_ex_en(z_idex),
    .ex_mem_en(z_exmem), .mem_wb_en(z_memwb), .id_ex_bubble(z_bub),
    .valid_id(z_vid), .valid_ex(z_vex), .valid_mem(z_vmem),
    .valid_wb(z_vwb), .retire(z_ret), .halted(z_halted),
    .stall_cycles(z_sc), .flush_count(z_fc), .retire_count(z_rc));

  // Model: mode 0 boot, 1 run, 2 drain, 3 halted; stg holds instruction
  // tags in ID, EX, MEM, WB (0 = empty).
  int     m_mode, m_boot, next_tag;
  int     stg[4];
  bit     m_halted;
  longint m_stall, m_flush, m_ret;

  int n_cmp = 0, n_fail = 0;
  int cyc_no = 0;
  int first_pc = -1, first_ret = -1;
  int drain_ret = 0;
  bit count_en = 1'b0;
  bit bd0_en = 1'b1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0d, expected %0d", nm, cyc_no, act, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_boot = 0; next_tag = 1; m_halted = 1'b0;
    m_stall = 0; m_flush = 0; m_ret = 0;
    for (int i = 0; i < 4; i++) stg[i] = 0;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_pc_enable"}, pc_enable, 0);
    chk({tag, "_enables"}, {if_id_en, id_ex_en, ex_mem_en, mem_wb_en}, 0);
    chk({tag, "_bubble"}, id_ex_bubble, 0);
    chk({tag, "_valids"}, {valid_id, valid_ex, valid_mem, valid_wb}, 0);
    chk({tag, "_retire"}, retire, 0);
    chk({tag, "_halted"}, halted, 0);
    chk({tag, "_counters"}, {stall_cycles, flush_count, retire_count}, 0);
  endtask

  // One clock cycle: drive inputs, compare at the falling edge, advance model.
  task automatic cyc(input bit sr, input bit fr, input bit mw, input bit iv, input bit hr);
    bit act, vid, vex, vmem, vwb, st, fl, fetch;
    bit e_pc, e_ifid, e_idex, e_exmem, e_memwb, e_bub, e_ret;
    int nx[4];
    stall_req = sr; flush_req = fr; mem_wait = mw; imem_valid = iv; halt_req = hr;
    @(negedge clk);
    act  = (m_mode == 1) || (m_mode == 2);
    vid  = stg[0] != 0; vex = stg[1] != 0; vmem = stg[2] != 0; vwb = stg[3] != 0;
    st   = sr & vid & vex;
    fl   = fr & vex;
    fetch = iv & (m_mode == 1);
    e_ret = vwb & !mw;
    {e_pc, e_ifid, e_idex, e_exmem, e_memwb, e_bub} = 6'b0;
    if (act && !mw) begin
      if (fl) {e_pc, e_ifid, e_idex, e_exmem, e_memwb} = 5'b11111;
      else if (st) {e_idex, e_exmem, e_memwb, e_bub} = 4'b1111;
      else begin
        e_pc = fetch;
        {e_ifid, e_idex, e_exmem, e_memwb} = 4'b1111;
      end
    end
    chk("pc_enable", pc_enable, e_pc);
    chk("if_id_en", if_id_en, e_ifid);
    chk("id_ex_en", id_ex_en, e_idex);
    chk("ex_mem_en", ex_mem_en, e_exmem);
    chk("mem_wb_en", mem_wb_en, e_memwb);
    chk("id_ex_bubble", id_ex_bubble, e_bub);
    chk("valid_bits", {valid_id, valid_ex, valid_mem, valid_wb}, {vid, vex, vmem, vwb});
    chk("retire", retire, e_ret);
    chk("halted", halted, m_halted);
    chk("stall_cycles", stall_cycles, PERF ? (m_stall & 64'hFFFF_FFFF) : 64'd0);
    chk("flush_count", flush_count, PERF ? (m_flush & 64'hFFFF_FFFF) : 64'd0);
    chk("retire_count", retire_count, PERF ? (m_ret & 64'hFFFF_FFFF) : 64'd0);
    if (bd0_en && cyc_no == 0)
      chk("bd0_outputs_c0", {z_pc, z_ifid, z_idex, z_exmem, z_memwb, z_bub, z_vid, z_vex,
                             z_vmem, z_vwb, z_ret, z_halted, |z_sc, |z_fc, |z_rc}, 0);
    if (bd0_en && cyc_no == 1) chk("bd0_pc_c1", z_pc, 1);
    if (pc_enable === 1'b1 && first_pc < 0) first_pc = cyc_no;
    if (retire === 1'b1 && first_ret < 0) first_ret = cyc_no;
    if (count_en && retire === 1'b1) drain_ret++;
    // advance model
    if (e_ret) m_ret++;
    nx = stg;
    if (act && !mw) begin
      if (fl) begin
        nx[0] = 0; nx[1] = 0; nx[2] = stg[1]; nx[3] = stg[2]; m_flush++;
      end else if (st) begin
        nx[1] = 0; nx[2] = stg[1]; nx[3] = stg[2]; m_stall++;
      end else begin
        nx[0] = fetch ? next_tag : 0;
        if (fetch) next_tag++;
        nx[1] = stg[0]; nx[2] = stg[1]; nx[3] = stg[2];
      end
    end
    case (m_mode)
      0: if (m_boot == BD) m_mode = hr ? 2 : 1; else m_boot++;
      1: if (hr) m_mode = 2;
      2: if (!vid && !vex && !vmem && !vwb && !mw) begin m_mode = 3; m_halted = 1'b1; end
      3: if (!hr) begin m_mode = 1; m_halted = 1'b0; end
      default: m_mode = 0;
    endcase
    stg = nx;
    @(posedge clk);
    #1;
    cyc_no++;
  endtask

  initial begin
    rst_n = 1'b0; stall_req = 1'b0; flush_req = 1'b0; mem_wait = 1'b0;
    imem_valid = 1'b0; halt_req = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_quiet("in_reset");
    rst_n = 1'b1;
    cyc_no = 0;

    // Boot and fill.
    repeat (10) cyc(0, 0, 0, 1, 0);
    bd0_en = 1'b0;
    chk("first_pc_cycle", first_pc, 3);
    chk("first_retire_cycle", first_ret, 7);

    // Single load-use stall.
    cyc(1, 0, 0, 1, 0);
    repeat (5) cyc(0, 0, 0, 1, 0);
    chk("stall_cnt_after_stall", stall_cycles, PERF ? 1 : 0);

    // Flush and stall together: flush wins.
    cyc(1, 1, 0, 1, 0);
    repeat (5) cyc(0, 0, 0, 1, 0);
    chk("flush_cnt_after_flush", flush_count, PERF ? 1 : 0);
    chk("stall_cnt_after_flush", stall_cycles, PERF ? 1 : 0);

    // Fetch gaps.
    repeat (2) cyc(0, 0, 0, 0, 0);
    repeat (5) cyc(0, 0, 0, 1, 0);

    // Three memory-wait cycles, with requests that must be ignored.
    cyc(0, 0, 1, 1, 0);
    cyc(1, 0, 1, 1, 0);
    cyc(1, 1, 1, 1, 0);
    repeat (3) cyc(0, 0, 0, 1, 0);
    chk("stall_cnt_after_wait", stall_cycles, PERF ? 1 : 0);
    chk("flush_cnt_after_wait", flush_count, PERF ? 1 : 0);

    // Debug halt with a full pipeline, then resume.
    cyc(0, 0, 0, 1, 1);
    count_en = 1'b1;
    repeat (6) cyc(0, 0, 0, 1, 1);
    count_en = 1'b0;
    chk("drain_retires", drain_ret, 4);
    chk("halted_after_drain", halted, 1);
    repeat (2) cyc(0, 0, 0, 1, 0);
    chk("resume_halted", halted, 0);
    chk("resume_pc_enable", pc_enable, 1);

    // Refill, then asynchronous reset between clock edges.
    repeat (6) cyc(0, 0, 0, 1, 0);
    #3;
    rst_n = 1'b0;
    #1;
    chk_quiet("async_reset");
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc_no = 0;
    repeat (9) cyc(0, 0, 0, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
